// File: rtl/fifo_queue.sv
// fifo_queue: single-clock first-in/first-out buffer on circular storage.
//
// Words leave in arrival order. Occupancy is tracked in its own counter
// (not from the pointer difference) and all status flags are registered
// from the next-state count, so they always agree with `count`.
//
// Ports:
//   clk          in   clock, all state changes on rising edge
//   rst          in   asynchronous active-high reset
//   push         in   write request, data_in sampled on the same edge
//   pop          in   read request
//   data_in      in   WIDTH  word to enqueue
//   data_out     out  WIDTH  word dequeued by the last accepted pop (held otherwise)
//   valid_out    out  one-cycle pulse after each accepted pop
//   count        out  occupancy 0..DEPTH
//   empty, full  out  count == 0 / count == DEPTH
//   almost_empty out  count <= ALMOST_EMPTY
//   almost_full  out  count >= ALMOST_FULL
//   overflow     out  sticky: push refused at full (without pop)
//   underflow    out  sticky: pop requested while empty
module fifo_queue #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ALMOST_FULL  = 14,
    parameter int unsigned ALMOST_EMPTY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             aempty_q, aempty_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        // Acceptance uses the registered flags; a push at full is allowed
        // when a pop in the same cycle frees the slot.
        pop_ok  = pop & ~empty_q;
        push_ok = push & (~full_q | pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem[rd_ptr_q];
            valid_d    = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push & full_q & ~pop) begin
            ovf_d = 1'b1;
        end
        if (pop & empty_q) begin
            unf_d = 1'b1;
        end

        empty_d  = (count_d == '0);
        full_d   = (count_d == CW'(DEPTH));
        aempty_d = (count_d <= CW'(ALMOST_EMPTY));
        afull_d  = (count_d >= CW'(ALMOST_FULL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            aempty_q   <= 1'b1;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            aempty_q   <= aempty_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_q;
    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
